// File: rtl/riscv_isa_pkg.sv
// Shared RISC-V ISA definitions used by the CSR sequencer and the CSR file.
package riscv_isa_pkg;

  // Zicsr funct3[1:0] operation encoding
  typedef enum logic [1:0] {
    CSR_RSV = 2'b00,
    CSR_RW  = 2'b01,
    CSR_SET = 2'b10,
    CSR_CLR = 2'b11
  } csr_op_t;

  // privilege levels (2'b10 is not a valid mode)
  typedef enum logic [1:0] {
    PRV_U = 2'b00,
    PRV_S = 2'b01,
    PRV_M = 2'b11
  } priv_t;

  // CSR address rw field value marking a read-only register
  localparam logic [1:0] CSR_ADR_RO = 2'b11;

  // read/write accessibility field of a CSR address
  function automatic logic [1:0] csr_adr_rw(input logic [11:0] adr);
    return adr[11:10];
  endfunction

  // lowest privilege level allowed to access a CSR address
  function automatic logic [1:0] csr_adr_priv(input logic [11:0] adr);
    return adr[9:8];
  endfunction

endpackage

// File: rtl/r5p_csr_chk.sv
// Combinational legality check for a Zicsr instruction.
module r5p_csr_chk
  import riscv_isa_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [11:0] adr,
  input  logic        wr_need,
  input  logic [1:0]  priv,
  output logic        illegal
);

  // reserved op, a write to a read-only CSR, or insufficient privilege
  assign illegal = (op == CSR_RSV)
                 | (wr_need & (csr_adr_rw(adr) == CSR_ADR_RO))
                 | (priv < csr_adr_priv(adr));

endmodule

// File: rtl/r5p_csr_seq.sv
// CSR access sequencer: accepts one Zicsr instruction, checks legality,
// performs the read-modify-write against the CSR file over req/ack and
// returns the old CSR value for GPR writeback.
module r5p_csr_seq
  import riscv_isa_pkg::*;
#(
  parameter int unsigned XW = 32
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          ins_vld,
  output logic          ins_rdy,
  input  logic [1:0]    ins_op,
  input  logic          ins_imm,
  input  logic [4:0]    ins_uimm,
  input  logic [XW-1:0] ins_src,
  input  logic [4:0]    ins_rd,
  input  logic [11:0]   ins_adr,
  input  logic [1:0]    priv,
  output logic          csr_req,
  output logic          csr_wen,
  output logic [11:0]   csr_adr,
  output logic [XW-1:0] csr_wdt,
  input  logic          csr_ack,
  input  logic [XW-1:0] csr_rdt,
  output logic          wb_vld,
  input  logic          wb_rdy,
  output logic          wb_wen,
  output logic [4:0]    wb_rd,
  output logic [XW-1:0] wb_dat,
  output logic          wb_exc
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    op_reg;
  logic [XW-1:0] msk_reg;
  logic [XW-1:0] old_reg;
  logic [XW-1:0] wdt_reg;
  logic [11:0]   adr_reg;
  logic [4:0]    rd_reg;
  logic          wr_need_reg;
  logic          wen_reg;
  logic          exc_reg;

  logic          accept;
  logic [XW-1:0] in_msk;
  logic          in_rd_need;
  logic          in_wr_need;
  logic          in_illegal;

  // new CSR value computed from the old value and the mask
  function automatic logic [XW-1:0] rmw(input logic [1:0] op,
                                        input logic [XW-1:0] old,
                                        input logic [XW-1:0] msk);
    case (op)
      CSR_SET: return old | msk;
      CSR_CLR: return old & ~msk;
      default: return msk;
    endcase
  endfunction

  assign ins_rdy    = (state_reg == IDLE);
  assign accept     = ins_vld & ins_rdy;
  assign in_msk     = ins_imm ? {{(XW-5){1'b0}}, ins_uimm} : ins_src;
  // SET/CLR always read; RW skips the read when the result would be discarded
  assign in_rd_need = (ins_op != CSR_RW) | (ins_rd != 5'd0);
  // SET/CLR with a zero rs1 index or zero immediate must not write
  assign in_wr_need = (ins_op == CSR_RW) | (ins_uimm != 5'd0);

  r5p_csr_chk u_chk (
    .op      (ins_op),
    .adr     (ins_adr),
    .wr_need (in_wr_need),
    .priv    (priv),
    .illegal (in_illegal)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // next-state logic; ack is only meaningful in RD and WR
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) begin
        if (in_illegal)       state_next = RSP;
        else if (!in_rd_need) state_next = WR;
        else                  state_next = RD;
      end
      RD:   if (csr_ack) state_next = wr_need_reg ? WR : RSP;
      WR:   if (csr_ack) state_next = RSP;
      RSP:  if (wb_rdy)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // instruction capture, read data capture and write data preparation;
  // write data is prepared on the read ack so it is stable for the whole WR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg      <= 2'b00;
      msk_reg     <= '0;
      old_reg     <= '0;
      wdt_reg     <= '0;
      adr_reg     <= '0;
      rd_reg      <= '0;
      wr_need_reg <= 1'b0;
      wen_reg     <= 1'b0;
      exc_reg     <= 1'b0;
    end else if (accept) begin
      op_reg      <= ins_op;
      msk_reg     <= in_msk;
      old_reg     <= '0;
      wdt_reg     <= in_msk;   // write-only path is always RW
      adr_reg     <= ins_adr;
      rd_reg      <= ins_rd;
      wr_need_reg <= in_wr_need;
      wen_reg     <= (ins_rd != 5'd0) & ~in_illegal;
      exc_reg     <= in_illegal;
    end else if ((state_reg == RD) && csr_ack) begin
      old_reg     <= csr_rdt;
      wdt_reg     <= rmw(op_reg, csr_rdt, msk_reg);
    end
  end

  assign csr_req = (state_reg == RD) | (state_reg == WR);
  assign csr_wen = (state_reg == WR);
  assign csr_adr = adr_reg;
  assign csr_wdt = wdt_reg;

  assign wb_vld  = (state_reg == RSP);
  assign wb_wen  = wb_vld & wen_reg;
  assign wb_rd   = rd_reg;
  assign wb_dat  = old_reg;
  assign wb_exc  = wb_vld & exc_reg;

endmodule

// File: tb/tb_r5p_csr_seq.sv
// Testbench for r5p_csr_seq: vector table with a scoreboard queue, a CSR
// responder with programmable ack delay, and hand sequences for reset/stray ack.
module tb_r5p_csr_seq;

  localparam int XW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ins_vld = 1'b0;
  logic          ins_rdy;
  logic [1:0]    ins_op = '0;
  logic          ins_imm = 1'b0;
  logic [4:0]    ins_uimm = '0;
  logic [XW-1:0] ins_src = '0;
  logic [4:0]    ins_rd = '0;
  logic [11:0]   ins_adr = '0;
  logic [1:0]    priv = 2'd3;
  logic          csr_req;
  logic          csr_wen;
  logic [11:0]   csr_adr;
  logic [XW-1:0] csr_wdt;
  logic          csr_ack = 1'b0;
  logic [XW-1:0] csr_rdt = '0;
  logic          wb_vld;
  logic          wb_rdy = 1'b0;
  logic          wb_wen;
  logic [4:0]    wb_rd;
  logic [XW-1:0] wb_dat;
  logic          wb_exc;

  always #5 clk = ~clk;

  r5p_csr_seq #(.XW(XW)) dut (
    .clk(clk), .rst(rst),
    .ins_vld(ins_vld), .ins_rdy(ins_rdy), .ins_op(ins_op), .ins_imm(ins_imm),
    .ins_uimm(ins_uimm), .ins_src(ins_src), .ins_rd(ins_rd), .ins_adr(ins_adr),
    .priv(priv),
    .csr_req(csr_req), .csr_wen(csr_wen), .csr_adr(csr_adr), .csr_wdt(csr_wdt),
    .csr_ack(csr_ack), .csr_rdt(csr_rdt),
    .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .wb_dat(wb_dat), .wb_exc(wb_exc)
  );

  typedef struct {
    logic [1:0]  op;
    logic        imm;
    logic [4:0]  uimm;
    logic [31:0] src;
    logic [4:0]  rd;
    logic [11:0] adr;
    logic [1:0]  priv;
    logic [31:0] rdt;
    int          ack_dly;
    int          wb_dly;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wdt;
    logic        exp_wen;
    logic [31:0] exp_dat;
    logic        exp_exc;
    int          exp_lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];
  vec_t exp_q [$];

  int checks = 0;
  int failures = 0;
  int cur_idx = 0;

  // responder state (written only by the responder process)
  int          ack_dly = 0;
  logic [31:0] cur_rdt = '0;
  logic        stray_ack = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, unstable_cnt = 0, drop_cnt = 0, a_cnt = 0;
  logic        a_pend = 1'b0;
  logic [11:0] h_adr = '0, last_wr_adr = '0;
  logic        h_wen = 1'b0;
  logic [31:0] h_wdt = '0, last_wdt = '0;

  // CSR file model: acks after ack_dly wait cycles, tracks request stability
  always @(negedge clk) begin
    if (rst) begin
      a_pend  = 1'b0;
      a_cnt   = 0;
      csr_ack = 1'b0;
    end else if (csr_req) begin
      if (a_pend) begin
        if (csr_adr !== h_adr || csr_wen !== h_wen || csr_wdt !== h_wdt)
          unstable_cnt++;
      end else begin
        a_pend = 1'b1;
        a_cnt  = 0;
        h_adr  = csr_adr;
        h_wen  = csr_wen;
        h_wdt  = csr_wdt;
      end
      if (a_cnt >= ack_dly) begin
        csr_ack = 1'b1;
        a_pend  = 1'b0;
        if (csr_wen) begin
          csr_rdt     = 32'hBAD0_BAD0;
          wr_cnt++;
          last_wdt    = csr_wdt;
          last_wr_adr = csr_adr;
        end else begin
          csr_rdt = cur_rdt;
          rd_cnt++;
        end
      end else begin
        csr_ack = 1'b0;
        a_cnt++;
      end
    end else begin
      if (a_pend) drop_cnt++;
      a_pend  = 1'b0;
      csr_ack = stray_ack;
      csr_rdt = 32'hFFFF_FFFF;
    end
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d %s act=%h exp=%h", cur_idx, nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d %s act=%b exp=%b", cur_idx, nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1 ({tag, "_ins_rdy"}, ins_rdy, 1'b1);
    chk1 ({tag, "_csr_req"}, csr_req, 1'b0);
    chk1 ({tag, "_csr_wen"}, csr_wen, 1'b0);
    chk32({tag, "_csr_adr"}, {20'b0, csr_adr}, 32'h0);
    chk32({tag, "_csr_wdt"}, csr_wdt, 32'h0);
    chk1 ({tag, "_wb_vld"}, wb_vld, 1'b0);
    chk1 ({tag, "_wb_wen"}, wb_wen, 1'b0);
    chk32({tag, "_wb_rd"}, {27'b0, wb_rd}, 32'h0);
    chk32({tag, "_wb_dat"}, wb_dat, 32'h0);
    chk1 ({tag, "_wb_exc"}, wb_exc, 1'b0);
  endtask

  task automatic drive(input vec_t v);
    ins_op   = v.op;
    ins_imm  = v.imm;
    ins_uimm = v.uimm;
    ins_src  = v.src;
    ins_rd   = v.rd;
    ins_adr  = v.adr;
    priv     = v.priv;
    ins_vld  = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int r0, w0, u0, d0, lat;
    ack_dly = v.ack_dly;
    cur_rdt = v.rdt;
    r0 = rd_cnt; w0 = wr_cnt; u0 = unstable_cnt; d0 = drop_cnt;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    #1;
    chk1("ins_rdy_idle", ins_rdy, 1'b1);
    @(posedge clk); #1;
    ins_vld = 1'b0;
    lat = 1;
    while (!wb_vld && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL v%0d scoreboard_empty act=0 exp=1", cur_idx);
      return;
    end
    e = exp_q.pop_front();
    chk32("latency", lat, e.exp_lat);
    chk32("rd_count", rd_cnt - r0, e.exp_rd);
    chk32("wr_count", wr_cnt - w0, e.exp_wr);
    if (e.exp_wr != 0) begin
      chk32("csr_wdt", last_wdt, e.exp_wdt);
      chk32("csr_wadr", {20'b0, last_wr_adr}, {20'b0, e.adr});
    end
    chk1 ("wb_wen", wb_wen, e.exp_wen);
    chk32("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
    chk32("wb_dat", wb_dat, e.exp_dat);
    chk1 ("wb_exc", wb_exc, e.exp_exc);
    chk1 ("ins_rdy_busy", ins_rdy, 1'b0);
    chk32("req_unstable", unstable_cnt - u0, 0);
    chk32("req_dropped", drop_cnt - d0, 0);
    for (int i = 0; i < e.wb_dly; i++) begin
      @(posedge clk); #1;
      chk1("wb_vld_hold", wb_vld, 1'b1);
      chk1("ins_rdy_hold", ins_rdy, 1'b0);
      chk32("wb_dat_hold", wb_dat, e.exp_dat);
    end
    wb_rdy = 1'b1;
    @(posedge clk); #1;
    wb_rdy = 1'b0;
    chk1("wb_vld_done", wb_vld, 1'b0);
    chk1("ins_rdy_done", ins_rdy, 1'b1);
  endtask

  initial begin
    int w0;
    // {op, imm, uimm, src, rd, adr, priv, rdt, ack_dly, wb_dly,
    //  exp_rd, exp_wr, exp_wdt, exp_wen, exp_dat, exp_exc, exp_lat}
    vt[0]  = '{2'b01, 1'b0, 5'd1,  32'hDEADBEEF, 5'd5,  12'h340, 2'd3, 32'h12345678, 0, 0, 1, 1, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b0, 3};
    vt[1]  = '{2'b10, 1'b0, 5'd0,  32'hFFFFFFFF, 5'd3,  12'hC00, 2'd0, 32'hA5A50001, 0, 0, 1, 0, 32'h0,        1'b1, 32'hA5A50001, 1'b0, 2};
    vt[2]  = '{2'b11, 1'b1, 5'd3,  32'h00000000, 5'd7,  12'h300, 2'd3, 32'h000000FF, 0, 0, 1, 1, 32'h000000FC, 1'b1, 32'h000000FF, 1'b0, 3};
    vt[3]  = '{2'b01, 1'b0, 5'd2,  32'h0BADF00D, 5'd0,  12'h340, 2'd3, 32'hCAFE0000, 0, 0, 0, 1, 32'h0BADF00D, 1'b0, 32'h0,        1'b0, 2};
    vt[4]  = '{2'b01, 1'b0, 5'd1,  32'h00001234, 5'd1,  12'hC00, 2'd3, 32'h11111111, 0, 0, 0, 0, 32'h0,        1'b0, 32'h0,        1'b1, 1};
    vt[5]  = '{2'b10, 1'b0, 5'd0,  32'h00000000, 5'd2,  12'h300, 2'd0, 32'h22222222, 0, 0, 0, 0, 32'h0,        1'b0, 32'h0,        1'b1, 1};
    vt[6]  = '{2'b00, 1'b0, 5'd1,  32'h00000005, 5'd4,  12'h340, 2'd3, 32'h33333333, 0, 0, 0, 0, 32'h0,        1'b0, 32'h0,        1'b1, 1};
    vt[7]  = '{2'b10, 1'b1, 5'h10, 32'hFFFFFFFF, 5'd9,  12'h305, 2'd3, 32'h00000F00, 0, 0, 1, 1, 32'h00000F10, 1'b1, 32'h00000F00, 1'b0, 3};
    vt[8]  = '{2'b11, 1'b0, 5'd4,  32'hFFFF0000, 5'd10, 12'h341, 2'd3, 32'h12345678, 0, 0, 1, 1, 32'h00005678, 1'b1, 32'h12345678, 1'b0, 3};
    vt[9]  = '{2'b10, 1'b1, 5'd1,  32'h00000000, 5'd0,  12'h100, 2'd1, 32'h00000020, 0, 0, 1, 1, 32'h00000021, 1'b0, 32'h00000020, 1'b0, 3};
    vt[10] = '{2'b01, 1'b0, 5'd3,  32'h00000001, 5'd0,  12'hC01, 2'd3, 32'h44444444, 0, 0, 0, 0, 32'h0,        1'b0, 32'h0,        1'b1, 1};
    vt[11] = '{2'b10, 1'b0, 5'd2,  32'h00000001, 5'd6,  12'hC00, 2'd3, 32'h55555555, 0, 0, 0, 0, 32'h0,        1'b0, 32'h0,        1'b1, 1};
    vt[12] = '{2'b01, 1'b0, 5'd8,  32'h55AA33CC, 5'd12, 12'h340, 2'd3, 32'h00000077, 4, 3, 1, 1, 32'h55AA33CC, 1'b1, 32'h00000077, 1'b0, 11};
    vt[13] = '{2'b01, 1'b0, 5'd8,  32'h600DCAFE, 5'd0,  12'h341, 2'd3, 32'h66666666, 2, 1, 0, 1, 32'h600DCAFE, 1'b0, 32'h0,        1'b0, 4};

    // reset state
    cur_idx = -1;
    #3;
    chk_reset_outputs("reset");
    @(negedge clk); #2;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cur_idx = i;
      run_vec(vt[i]);
      $display("v%0d op=%b imm=%b uimm=%h adr=%h priv=%0d -> checks=%0d failures=%0d",
               i, vt[i].op, vt[i].imm, vt[i].uimm, vt[i].adr, vt[i].priv, checks, failures);
    end

    // acks while idle are ignored
    cur_idx = 100;
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk1("stray_ins_rdy", ins_rdy, 1'b1);
      chk1("stray_req", csr_req, 1'b0);
      chk1("stray_wb_vld", wb_vld, 1'b0);
    end
    @(negedge clk);
    stray_ack = 1'b0;
    $display("stray ack in IDLE -> checks=%0d failures=%0d", checks, failures);

    // reset while a write request is pending abandons it
    cur_idx = 101;
    ack_dly = 50;
    w0 = wr_cnt;
    @(negedge clk);
    drive(vt[3]);
    @(posedge clk); #1;
    ins_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("pend_req", csr_req, 1'b1);
    chk1("pend_wen", csr_wen, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk); #2;
    rst = 1'b0;
    ack_dly = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk1("no_reissue", csr_req, 1'b0);
    end
    chk32("abandoned_wr_count", wr_cnt - w0, 0);
    $display("reset during WR -> checks=%0d failures=%0d", checks, failures);

    // normal operation after the abandoned transaction
    cur_idx = 102;
    run_vec(vt[0]);
    $display("post-reset RMW -> checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r5p_csr_seq.md
Name: r5p_csr_seq

Overview:
CSR access sequencer: the initiator side of the CSR port. It takes one decoded Zicsr instruction (CSRRW/S/C and their immediate forms) from the decode stage and checks legality. It then issues the read and/or write transactions to the CSR file over a req/ack handshake, performing the read-modify-write itself. The old CSR value goes to GPR writeback. It sits between decode/execute and the CSR file in the multicycle r5p core.

Parameters:
XW, 32, data width of GPR and CSR values

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ins_vld  in  1  CSR instruction valid
ins_rdy  out  1  sequencer can accept an instruction
ins_op  in  2  funct3[1:0]: 01 RW, 10 SET, 11 CLR, 00 reserved
ins_imm  in  1  1 = immediate form (funct3[2])
ins_uimm  in  5  rs1 field: uimm value or rs1 index
ins_src  in  XW  rs1 register value
ins_rd  in  5  destination register index
ins_adr  in  12  CSR address
priv  in  2  current privilege level (0 U, 1 S, 3 M)
csr_req  out  1  CSR transaction request
csr_wen  out  1  1 write, 0 read
csr_adr  out  12  CSR address
csr_wdt  out  XW  CSR write data
csr_ack  in  1  CSR transaction complete; rdt valid this cycle for reads
csr_rdt  in  XW  CSR read data
wb_vld  out  1  result/retire valid
wb_rdy  in  1  writeback accepts result
wb_wen  out  1  write GPR rd
wb_rd  out  5  GPR index
wb_dat  out  XW  old CSR value
wb_exc  out  1  illegal instruction exception

Behaviour:
- Reset (async): state IDLE; ins_rdy=1, csr_req=0, csr_wen=0, csr_adr=0, csr_wdt=0, wb_vld=0, wb_wen=0, wb_rd=0, wb_dat=0, wb_exc=0. Reset mid-transaction abandons it; no req is reissued.
- ins_rdy=1 only in IDLE. Handshake on ins_vld & ins_rdy: capture all ins_* fields and priv.
- Mask src: msk = ins_imm ? zero-extended uimm : ins_src.
- rd_need = (op!=RW) | (rd!=0). wr_need = (op==RW) | (uimm!=0); the uimm!=0 test covers both the rs1 index and the immediate.
- Illegal = (op==00) | (wr_need & adr[11:10]==11) | (priv < adr[9:8]).
- FSM states are IDLE, RD, WR, RSP.
- IDLE -> RSP when illegal; WR otherwise, when !rd_need; RD otherwise.
- RD: csr_req=1, csr_wen=0. On csr_ack, capture csr_rdt into old. Then go to WR if wr_need, else RSP.
- WR: csr_req=1, csr_wen=1, csr_wdt = RW: msk; SET: old|msk; CLR: old&~msk. Next state RSP on csr_ack.
- RSP: wb_vld=1. wb_wen = (rd!=0) & !exc. wb_dat = old (0 if no read). wb_exc = illegal. Next state IDLE on wb_rdy.
- csr_adr, csr_wen and csr_wdt are registered and held stable while csr_req=1 until ack. csr_req never drops without ack.
- ack is allowed in the first req cycle. Minimum latency from accept to wb_vld:
  - full RMW: 3 cycles
  - single access: 2 cycles
  - illegal: 1 cycle
- csr_ack outside RD/WR is ignored.
- No CSR transaction is issued for an illegal instruction.

Decomposition:
- riscv_isa_pkg gains:
  - CSR op encoding enum (CSR_RW/SET/CLR, shared with the CSR file)
  - a privilege-level enum
  - a CSR address-field helper (rw bits [11:10], priv bits [9:8])
- FSM state enum is local.
- One natural sub-module: r5p_csr_chk, the combinational legality check (op, adr, wr_need, priv -> illegal).

Test Plan:
- CSRRW adr=0x340, rd=5, src=0xDEADBEEF, csr_rdt=0x12345678, ack immediate -> RD then WR with wdt=0xDEADBEEF; wb_dat=0x12345678, wb_wen=1, wb_vld 3 cycles after accept.
- CSRRS rs1=x0 adr=0xC00 rd=3, priv=0 -> read only, no write (read-only CSR legal); wb_dat=csr_rdt; wb_exc=0.
- CSRRCI uimm=0x3 adr=0x300 priv=3, old=0xFF -> wdt=0xFC; CSRRW rd=x0 -> no RD, single write, wb_wen=0.
- Illegal cases:
  - CSRRW to 0xC00 -> wb_exc=1, csr_req never asserted
  - adr=0x300 with priv=0 -> wb_exc=1
  - op=00 -> wb_exc=1
- Stall: csr_ack delayed 4 cycles and wb_rdy delayed 3 cycles -> csr_req/adr/wdt stable; ins_rdy=0 until wb handshake.
- Assert rst while in WR with req pending -> all outputs reset values immediately; next instruction accepted normally.
